keystream_xor: RTL and testbench

Keystream consumer for the stream-cipher datapath. Samples the one-bit LFSR keystream output every clock and packs it LSB-first into bytes. Buffers the bytes in a small FIFO and XORs each one with a plaintext byte taken over a valid/ready handshake. The result is presented as a registered ciphertext byte on a second valid/ready handshake. It sits directly downstream of the LFSR's `shift_seed` output, which advances every clock and has no enable.

---
 rtl/keystream_xor.sv | 104 ++++++++++
 tb/tb_keystream_xor.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keystream_xor.sv
// Packs the free-running one-bit LFSR keystream LSB-first into bytes, buffers them
// in a small FIFO and XORs each buffered byte with an incoming plaintext byte.
module keystream_xor #(
  parameter int KS_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       ks_sync,
  input  logic                       ks_bit,
  input  logic [7:0]                 pt_data,
  input  logic                       pt_valid,
  output logic                       pt_ready,
  output logic [7:0]                 ct_data,
  output logic                       ct_valid,
  input  logic                       ct_ready,
  output logic [$clog2(KS_DEPTH):0]  ks_level,
  output logic                       ks_overflow
);

  localparam int AW = $clog2(KS_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(KS_DEPTH);

  logic [2:0]    cnt;
  logic [7:0]    pack;
  logic [7:0]    fifo_mem [KS_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic [7:0] new_byte;
  logic [7:0] fifo_head;
  logic       byte_done;
  logic       accept;
  logic       push;

  assign new_byte  = {ks_bit, pack[7:1]};
  assign fifo_head = fifo_mem[rd_ptr];
  assign byte_done = !ks_sync && (cnt == 3'd7);

  // Handshakes: a transfer happens on an edge where valid && ready are both 1.
  // pt_ready needs a buffered keystream byte and a free (or draining) output
  // register, and drops during ks_sync; ct_valid holds with ct_data stable until
  // ct_ready is seen, and a new byte may be accepted on the draining edge itself.
  assign pt_ready = (ks_level != '0) && (!ct_valid || ct_ready) && !ks_sync;
  assign accept   = pt_valid && pt_ready;

  // A full FIFO still takes the new byte when the head is popped on the same edge.
  assign push = byte_done && ((ks_level < DEPTH_L) || accept);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= new_byte;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= 3'd0;
      pack        <= 8'h00;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ks_level    <= '0;
      ks_overflow <= 1'b0;
    end else if (ks_sync) begin
      cnt         <= 3'd0;
      pack        <= 8'h00;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ks_level    <= '0;
      ks_overflow <= 1'b0;
    end else begin
      // The LFSR cannot stall, so the packer advances even when bytes are dropped.
      cnt  <= cnt + 3'd1;
      pack <= new_byte;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (byte_done && !push) begin
        ks_overflow <= 1'b1;
      end
      if (accept) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, accept})
        2'b10:   ks_level <= ks_level + 1'b1;
        2'b01:   ks_level <= ks_level - 1'b1;
        default: ks_level <= ks_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ct_valid <= 1'b0;
      ct_data  <= 8'h00;
    end else if (accept) begin
      ct_valid <= 1'b1;
      ct_data  <= pt_data ^ fifo_head;
    end else if (ct_valid && ct_ready) begin
      ct_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keystream_xor.sv
// Directed bench for keystream_xor: packing, XOR, overflow, backpressure, sync and reset.
module tb_keystream_xor;

  logic       clk;
  logic       reset_n;
  logic       ks_sync;
  logic       ks_bit;
  logic [7:0] pt_data;
  logic       pt_valid;
  logic       pt_ready;
  logic [7:0] ct_data;
  logic       ct_valid;
  logic       ct_ready;
  logic [2:0] ks_level;
  logic       ks_overflow;

  int n_checks;
  int n_fail;
  logic [7:0] exp_q[$];

  keystream_xor #(.KS_DEPTH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ks_sync    (ks_sync),
    .ks_bit     (ks_bit),
    .pt_data    (pt_data),
    .pt_valid   (pt_valid),
    .pt_ready   (pt_ready),
    .ct_data    (ct_data),
    .ct_valid   (ct_valid),
    .ct_ready   (ct_ready),
    .ks_level   (ks_level),
    .ks_overflow(ks_overflow)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    ks_sync  = 1'b0;
    ks_bit   = 1'b0;
    pt_data  = 8'h00;
    pt_valid = 1'b0;
    ct_ready = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Driver: sends the low n bits of b, LSB first, one per edge
  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      ks_bit = b[i];
      step();
    end
  endtask

  task automatic test_reset();
    do_reset();
    pt_valid = 1'b1;
    ct_ready = 1'b1;
    #1;
    n_checks++; if (ct_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ct_valid got=%b exp=0", ct_valid); end
    n_checks++; if (ct_data !== 8'h00) begin n_fail++; $display("FAIL reset_ct_data got=%h exp=00", ct_data); end
    n_checks++; if (ks_level !== 3'd0) begin n_fail++; $display("FAIL reset_ks_level got=%0d exp=0", ks_level); end
    n_checks++; if (ks_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", ks_overflow); end
    n_checks++; if (pt_ready !== 1'b0) begin n_fail++; $display("FAIL reset_pt_ready got=%b exp=0", pt_ready); end
  endtask

  task automatic test_known_byte();
    do_reset();
    ct_ready = 1'b1;
    send_bits(8'hA5, 8);
    n_checks++; if (ks_level !== 3'd1) begin n_fail++; $display("FAIL known_level got=%0d exp=1", ks_level); end
    n_checks++; if (pt_ready !== 1'b1) begin n_fail++; $display("FAIL known_pt_ready got=%b exp=1", pt_ready); end
    pt_data  = 8'h3C;
    pt_valid = 1'b1;
    ks_bit   = 1'b0;
    step();
    pt_valid = 1'b0;
    n_checks++; if (ct_valid !== 1'b1) begin n_fail++; $display("FAIL known_ct_valid got=%b exp=1", ct_valid); end
    n_checks++; if (ct_data !== 8'h99) begin n_fail++; $display("FAIL known_ct_data got=%h exp=99", ct_data); end
    n_checks++; if (ks_level !== 3'd0) begin n_fail++; $display("FAIL known_level_after got=%0d exp=0", ks_level); end
    n_checks++; if (pt_ready !== 1'b0) begin n_fail++; $display("FAIL known_pt_ready_empty got=%b exp=0", pt_ready); end
    step();
    n_checks++; if (ct_valid !== 1'b0) begin n_fail++; $display("FAIL known_release got=%b exp=0", ct_valid); end
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    do_reset();
    ks_bit = 1'b1;
    repeat (32) step();
    n_checks++; if (ks_level !== 3'd4) begin n_fail++; $display("FAIL ovf_level_full got=%0d exp=4", ks_level); end
    repeat (7) step();
    n_checks++; if (ks_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early got=%b exp=0", ks_overflow); end
    step();
    n_checks++; if (ks_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%b exp=1", ks_overflow); end
    n_checks++; if (ks_level !== 3'd4) begin n_fail++; $display("FAIL ovf_level_hold got=%0d exp=4", ks_level); end
    ct_ready = 1'b1;
    pt_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = 8'h21 * (i + 1);
      pt_data = d;
      step();
      n_checks++; if (ct_data !== (d ^ 8'hFF)) begin n_fail++; $display("FAIL ovf_drain%0d got=%h exp=%h", i, ct_data, d ^ 8'hFF); end
    end
    pt_valid = 1'b0;
    n_checks++; if (ks_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=1", ks_overflow); end
    ks_sync = 1'b1;
    step();
    ks_sync = 1'b0;
    n_checks++; if (ks_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_sync_clear got=%b exp=0", ks_overflow); end
  endtask

  task automatic test_backpressure();
    do_reset();
    send_bits(8'h5A, 8);
    send_bits(8'hC3, 8);
    ks_bit   = 1'b0;
    pt_data  = 8'h11;
    pt_valid = 1'b1;
    ct_ready = 1'b0;
    #1;
    n_checks++; if (pt_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_first got=%b exp=1", pt_ready); end
    step();
    pt_data = 8'h22;
    n_checks++; if (ct_data !== 8'h4B) begin n_fail++; $display("FAIL bp_first_ct got=%h exp=4b", ct_data); end
    n_checks++; if (pt_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_blocked got=%b exp=0", pt_ready); end
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if (ct_data !== 8'h4B || ct_valid !== 1'b1 || pt_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d got=%h/%b/%b exp=4b/1/0", i, ct_data, ct_valid, pt_ready);
      end
    end
    ct_ready = 1'b1;
    #1;
    n_checks++; if (pt_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_release got=%b exp=1", pt_ready); end
    step();
    pt_valid = 1'b0;
    n_checks++; if (ct_data !== 8'hE1 || ct_valid !== 1'b1) begin n_fail++; $display("FAIL bp_no_bubble got=%h/%b exp=e1/1", ct_data, ct_valid); end
    n_checks++; if (ks_level !== 3'd1) begin n_fail++; $display("FAIL bp_level got=%0d exp=1", ks_level); end
    step();
    n_checks++; if (ct_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got=%b exp=0", ct_valid); end
  endtask

  task automatic test_full_pop();
    logic [7:0] d;
    logic [7:0] k;
    do_reset();
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h7E);
    exp_q.push_back(8'hB4);
    exp_q.push_back(8'h6D);
    send_bits(8'h01, 8);
    send_bits(8'h80, 8);
    send_bits(8'h7E, 8);
    send_bits(8'hB4, 8);
    n_checks++; if (ks_level !== 3'd4) begin n_fail++; $display("FAIL fp_full got=%0d exp=4", ks_level); end
    send_bits(8'h6D, 7);
    ks_bit   = 1'b0;
    ct_ready = 1'b1;
    pt_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d = 8'h13 * i;
      pt_data = d;
      step();
      ks_bit = 1'b0;
      k = exp_q.pop_front();
      n_checks++; if (ct_data !== (d ^ k)) begin n_fail++; $display("FAIL fp_ct%0d got=%h exp=%h", i, ct_data, d ^ k); end
      if (i == 0) begin
        n_checks++; if (ks_level !== 3'd4) begin n_fail++; $display("FAIL fp_level_same got=%0d exp=4", ks_level); end
        n_checks++; if (ks_overflow !== 1'b0) begin n_fail++; $display("FAIL fp_no_ovf got=%b exp=0", ks_overflow); end
      end
    end
    pt_valid = 1'b0;
    n_checks++; if (ks_level !== 3'd0) begin n_fail++; $display("FAIL fp_empty got=%0d exp=0", ks_level); end
  endtask

  task automatic test_sync_mid();
    do_reset();
    send_bits(8'h96, 8);
    send_bits(8'h0F, 8);
    pt_data  = 8'hAA;
    pt_valid = 1'b1;
    send_bits(8'h33, 1);
    pt_valid = 1'b0;
    send_bits(8'h33 >> 1, 7);
    send_bits(8'h15, 5);
    n_checks++; if (ks_level !== 3'd2 || ct_valid !== 1'b1) begin n_fail++; $display("FAIL sync_pre got=%0d/%b exp=2/1", ks_level, ct_valid); end
    ks_sync  = 1'b1;
    ks_bit   = 1'b1;
    pt_data  = 8'hFF;
    pt_valid = 1'b1;
    ct_ready = 1'b1;
    #1;
    n_checks++; if (pt_ready !== 1'b0) begin n_fail++; $display("FAIL sync_forces_ready got=%b exp=0", pt_ready); end
    step();
    ks_sync  = 1'b0;
    pt_valid = 1'b0;
    n_checks++; if (ks_level !== 3'd0) begin n_fail++; $display("FAIL sync_level got=%0d exp=0", ks_level); end
    n_checks++; if (ks_overflow !== 1'b0) begin n_fail++; $display("FAIL sync_ovf got=%b exp=0", ks_overflow); end
    n_checks++; if (ct_valid !== 1'b0 || ct_data !== 8'h3C) begin n_fail++; $display("FAIL sync_ct_drain got=%b/%h exp=0/3c", ct_valid, ct_data); end
    send_bits(8'hE7, 7);
    n_checks++; if (ks_level !== 3'd0) begin n_fail++; $display("FAIL sync_7bits got=%0d exp=0", ks_level); end
    send_bits(8'hE7 >> 7, 1);
    n_checks++; if (ks_level !== 3'd1) begin n_fail++; $display("FAIL sync_8bits got=%0d exp=1", ks_level); end
    pt_data  = 8'h00;
    pt_valid = 1'b1;
    step();
    pt_valid = 1'b0;
    n_checks++; if (ct_data !== 8'hE7 || ct_valid !== 1'b1) begin n_fail++; $display("FAIL sync_first_byte got=%h/%b exp=e7/1", ct_data, ct_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_bits(8'h5A, 8);
    send_bits(8'h77, 8);
    ks_bit   = 1'b0;
    pt_data  = 8'h0F;
    pt_valid = 1'b1;
    step();
    pt_valid = 1'b0;
    ct_ready = 1'b1;
    n_checks++; if (ct_valid !== 1'b1 || ks_level !== 3'd1) begin n_fail++; $display("FAIL rmid_pre got=%b/%0d exp=1/1", ct_valid, ks_level); end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++; if (ct_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_ct_valid got=%b exp=0", ct_valid); end
    n_checks++; if (ks_level !== 3'd0) begin n_fail++; $display("FAIL rmid_level got=%0d exp=0", ks_level); end
    n_checks++; if (pt_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_pt_ready got=%b exp=0", pt_ready); end
    n_checks++; if (ct_data !== 8'h00) begin n_fail++; $display("FAIL rmid_ct_data got=%h exp=00", ct_data); end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    send_bits(8'hC9, 7);
    n_checks++; if (ks_level !== 3'd0) begin n_fail++; $display("FAIL rmid_7bits got=%0d exp=0", ks_level); end
    send_bits(8'hC9 >> 7, 1);
    n_checks++; if (ks_level !== 3'd1) begin n_fail++; $display("FAIL rmid_8bits got=%0d exp=1", ks_level); end
    pt_data  = 8'hFF;
    pt_valid = 1'b1;
    step();
    pt_valid = 1'b0;
    n_checks++; if (ct_data !== 8'h36) begin n_fail++; $display("FAIL rmid_ct got=%h exp=36", ct_data); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_known_byte();
    test_overflow();
    test_backpressure();
    test_full_pop();
    test_sync_mid();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
